// File: rtl/cfg_pkg.sv
// Shared definitions for the configuration-write path between ControlUnit and config_store.
// Word width, FSM state encoding and debug/settle counter widths live here.
package cfg_pkg;

   localparam int CFG_WIDTH = 35;
   localparam int DBG_W     = 2;
   localparam int SETTLE_W  = 8;

   typedef enum logic [DBG_W-1:0] {
      ST_EMPTY   = 2'd0,
      ST_IDLE    = 2'd1,
      ST_PENDING = 2'd2
   } state_t;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   logic [CNT_W-1:0] count_q;
   logic [CNT_W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {CNT_W{1'b1}})) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/config_store.sv
// Shadow-then-commit configuration register: write bursts coalesce into one commit
// after SETTLE quiet cycles; the active word is served through a registered read port.
module config_store
   import cfg_pkg::*;
#(
   parameter int WIDTH  = CFG_WIDTH,
   parameter int SETTLE = 4,
   parameter int CNT_W  = 8
) (
   input  logic             clk,
   input  logic             arst,
   input  logic             write_en,
   input  logic [WIDTH-1:0] config_in,
   input  logic             rd_req,
   output logic             rd_ack,
   output logic [WIDTH-1:0] rd_data,
   output logic             rd_err,
   output logic [WIDTH-1:0] cfg_active,
   output logic             cfg_valid,
   output logic             apply_pulse,
   output logic [CNT_W-1:0] write_count,
   output logic [DBG_W-1:0] dbg_state
);

   localparam logic [SETTLE_W-1:0] SETTLE_LOAD = SETTLE_W'(SETTLE - 1);

   state_t              state_q,   state_d;
   logic [SETTLE_W-1:0] cnt_q,     cnt_d;
   logic [WIDTH-1:0]    shadow_q,  shadow_d;
   logic [WIDTH-1:0]    active_q,  active_d;
   logic                valid_q,   valid_d;
   logic                apply_q,   apply_d;
   logic                rd_ack_q,  rd_ack_d;
   logic [WIDTH-1:0]    rd_data_q, rd_data_d;
   logic                rd_err_q,  rd_err_d;

   always_comb begin
      // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
      state_d  = state_q;
      cnt_d    = cnt_q;
      shadow_d = shadow_q;
      active_d = active_q;
      valid_d  = valid_q;
      apply_d  = 1'b0;

      // A write in any state restarts the settle window, so it beats a commit at the same edge.
      if (write_en) begin
         shadow_d = config_in;
         cnt_d    = SETTLE_LOAD;
         state_d  = ST_PENDING;
      end else if (state_q == ST_PENDING) begin
         if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
         end else begin
            active_d = shadow_q;
            valid_d  = 1'b1;
            apply_d  = 1'b1;
            state_d  = ST_IDLE;
         end
      end
   end

   // Reads sample the pre-edge active word and valid flag, so a coincident commit is not visible.
   always_comb begin
      rd_ack_d  = rd_req;
      rd_data_d = rd_data_q;
      rd_err_d  = 1'b0;
      if (rd_req) begin
         rd_data_d = active_q;
         rd_err_d  = ~valid_q;
      end
   end

   always_ff @(posedge clk or posedge arst) begin
      if (arst) begin
         state_q   <= ST_EMPTY;
         cnt_q     <= '0;
         shadow_q  <= '0;
         active_q  <= '0;
         valid_q   <= 1'b0;
         apply_q   <= 1'b0;
         rd_ack_q  <= 1'b0;
         rd_data_q <= '0;
         rd_err_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of order.
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         shadow_q  <= shadow_d;
         active_q  <= active_d;
         valid_q   <= valid_d;
         apply_q   <= apply_d;
         rd_ack_q  <= rd_ack_d;
         rd_data_q <= rd_data_d;
         rd_err_q  <= rd_err_d;
      end
   end

   sat_counter #(
      .CNT_W(CNT_W)
   ) u_write_count (
      .clk  (clk),
      .arst (arst),
      .inc  (write_en),
      .count(write_count)
   );

   assign cfg_active  = active_q;
   assign cfg_valid   = valid_q;
   assign apply_pulse = apply_q;
   assign rd_ack      = rd_ack_q;
   assign rd_data     = rd_data_q;
   assign rd_err      = rd_err_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_config_store.sv
// Scoreboard bench for config_store: expected reads and commits are queued at stimulus
// time and retired by a monitor when rd_ack / apply_pulse appear.
module tb_config_store;

   localparam int W      = 35;
   localparam int CW     = 8;
   localparam int SETTLE = 4;

   typedef struct packed {
      logic [W-1:0] data;
      logic         err;
   } rd_exp_t;

   logic          clk = 1'b0;
   logic          arst;
   logic          write_en;
   logic [W-1:0]  config_in;
   logic          rd_req;
   logic          rd_ack;
   logic [W-1:0]  rd_data;
   logic          rd_err;
   logic [W-1:0]  cfg_active;
   logic          cfg_valid;
   logic          apply_pulse;
   logic [CW-1:0] write_count;
   logic [1:0]    dbg_state;

   rd_exp_t       rd_q[$];
   logic [W-1:0]  cm_q[$];
   rd_exp_t       mon_e;
   int            n_checks = 0;
   int            n_fail   = 0;
   int            n_apply  = 0;
   int            apply_mark;

   config_store #(
      .WIDTH (W),
      .SETTLE(SETTLE),
      .CNT_W (CW)
   ) dut (
      .clk        (clk),
      .arst       (arst),
      .write_en   (write_en),
      .config_in  (config_in),
      .rd_req     (rd_req),
      .rd_ack     (rd_ack),
      .rd_data    (rd_data),
      .rd_err     (rd_err),
      .cfg_active (cfg_active),
      .cfg_valid  (cfg_valid),
      .apply_pulse(apply_pulse),
      .write_count(write_count),
      .dbg_state  (dbg_state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      arst = 1'b1;
      #2;
      arst = 1'b0;
   endtask

   task automatic write_word(input logic [W-1:0] val);
      write_en  = 1'b1;
      config_in = val;
      tick();
      write_en  = 1'b0;
   endtask

   // Monitor on the falling edge, away from the sampling edge.
   always @(negedge clk) begin
      if (!arst) begin
         if (rd_ack) begin
            if (rd_q.size() == 0) begin
               check("rd_ack_unexpected", rd_ack, 0);
            end else begin
               mon_e = rd_q.pop_front();
               check("rd_data", rd_data, mon_e.data);
               check("rd_err", rd_err, mon_e.err);
            end
         end
         if (apply_pulse) begin
            n_apply++;
            if (cm_q.size() == 0) begin
               check("apply_unexpected", apply_pulse, 0);
            end else begin
               check("commit_value", cfg_active, cm_q.pop_front());
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      arst      = 1'b1;
      write_en  = 1'b0;
      config_in = '0;
      rd_req    = 1'b0;
      #12;
      arst = 1'b0;

      // Reset state after idling
      repeat (10) tick();
      check("rst_dbg_state", dbg_state, 0);
      check("rst_cfg_valid", cfg_valid, 0);
      check("rst_cfg_active", cfg_active, 0);
      check("rst_apply", apply_pulse, 0);
      check("rst_rd_ack", rd_ack, 0);
      check("rst_write_count", write_count, 0);

      // Read before any commit: data 0, err 1
      rd_req = 1'b1;
      rd_q.push_back('{data: '0, err: 1'b1});
      tick();
      rd_req = 1'b0;
      check("rd_ack_first", rd_ack, 1);
      tick();
      check("rd_ack_drop", rd_ack, 0);

      // Single write, commit SETTLE edges later
      cm_q.push_back(35'h0_1234_5678);
      write_word(35'h0_1234_5678);
      check("single_pending", dbg_state, 2);
      check("single_count", write_count, 1);
      repeat (SETTLE - 1) tick();
      check("single_not_yet", cfg_active, 0);
      check("single_no_pulse_early", apply_pulse, 0);
      tick();
      check("single_active", cfg_active, 35'h0_1234_5678);
      check("single_valid", cfg_valid, 1);
      check("single_pulse", apply_pulse, 1);
      check("single_idle", dbg_state, 1);
      tick();
      check("single_pulse_once", apply_pulse, 0);

      // Burst of three writes three cycles apart coalesces into one commit
      do_reset();
      apply_mark = n_apply;
      cm_q.push_back(35'h3);
      for (int i = 1; i <= 3; i++) begin
         write_word(W'(i));
         if (i < 3) begin
            repeat (2) tick();
            check("burst_no_commit", cfg_valid, 0);
         end
      end
      repeat (SETTLE - 1) tick();
      check("burst_not_yet", cfg_active, 0);
      tick();
      check("burst_active", cfg_active, 35'h3);
      check("burst_count", write_count, 3);
      tick();
      check("burst_one_pulse", n_apply - apply_mark, 1);

      // Read coinciding with a commit returns the pre-commit word
      cm_q.push_back(35'hA);
      write_word(35'hA);
      repeat (SETTLE) tick();
      check("rc_active_a", cfg_active, 35'hA);
      cm_q.push_back(35'hB);
      write_word(35'hB);
      repeat (SETTLE - 1) tick();
      rd_req = 1'b1;
      rd_q.push_back('{data: 35'hA, err: 1'b0});
      tick();
      check("rc_active_b", cfg_active, 35'hB);
      rd_q.push_back('{data: 35'hB, err: 1'b0});
      tick();
      rd_req = 1'b0;
      tick();
      check("rc_ack_drop", rd_ack, 0);
      check("rc_data_hold", rd_data, 35'hB);

      // Asynchronous reset in the middle of a pending window
      write_word(35'h5A5A);
      repeat (2) tick();
      check("ar_pending", dbg_state, 2);
      apply_mark = n_apply;
      #2;
      arst = 1'b1;
      #1;
      check("ar_active", cfg_active, 0);
      check("ar_valid", cfg_valid, 0);
      check("ar_state", dbg_state, 0);
      check("ar_count", write_count, 0);
      #2;
      arst = 1'b0;
      repeat (8) tick();
      check("ar_no_pulse", n_apply - apply_mark, 0);
      check("ar_still_empty", dbg_state, 0);

      // Long write stream: counter saturates, commit follows the last word
      write_en = 1'b1;
      for (int i = 0; i < 260; i++) begin
         config_in = W'(i);
         tick();
      end
      write_en = 1'b0;
      cm_q.push_back(W'(259));
      check("sat_count", write_count, 255);
      check("sat_pending", dbg_state, 2);
      check("sat_no_commit", cfg_valid, 0);
      repeat (SETTLE - 1) tick();
      check("sat_not_yet", apply_pulse, 0);
      tick();
      check("sat_active", cfg_active, W'(259));
      check("sat_pulse", apply_pulse, 1);
      repeat (2) tick();
      check("sat_count_hold", write_count, 255);

      check("total_pulses", n_apply, 5);
      check("rd_queue_empty", rd_q.size(), 0);
      check("cm_queue_empty", cm_q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/config_store.md
Name: config_store

Overview:
- Receiving end of the ControlUnit configuration-write interface. ControlUnit is the writer; this block is the reader.
- Captures each accepted 35-bit configuration word presented with write_en into a shadow register.
- Commits the shadow word to the active configuration only after a quiet settle window, so write bursts coalesce into one commit.
- Serves the active configuration to downstream logic through a single-cycle read request/acknowledge port.

Parameters:
- WIDTH, 35, configuration word width; matches ControlUnit configout.
- SETTLE, 4, quiet cycles after the last write before commit; legal range 1..255.
- CNT_W, 8, width of the saturating write counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- arst  input  1  reset; asynchronous, active-high.
- write_en  input  1  write strobe from ControlUnit; every cycle sampled high is one write.
- config_in  input  WIDTH  configuration word from ControlUnit configout; valid when write_en=1.
- rd_req  input  1  read request from a downstream consumer.
- rd_ack  output  1  registered one-cycle acknowledge for each sampled rd_req.
- rd_data  output  WIDTH  active configuration returned with rd_ack.
- rd_err  output  1  with rd_ack: 1 if no configuration has ever been committed.
- cfg_active  output  WIDTH  current committed configuration, continuously visible.
- cfg_valid  output  1  set by the first commit; stays set until reset.
- apply_pulse  output  1  one-cycle pulse in the cycle after a commit edge.
- write_count  output  CNT_W  number of sampled writes, saturating at all-ones.
- dbg_state  output  2  state encoding: EMPTY=0, IDLE=1, PENDING=2; value 3 is never produced.

Behaviour:
- Reset (arst=1, any time, asynchronous):
  - all outputs 0; shadow=0; settle counter=0; state=EMPTY.
  - A pending commit is discarded.
- Write acceptance, any state, at edge E with write_en=1:
  - shadow<=config_in; cnt<=SETTLE-1; state<=PENDING; write_count increments unless saturated.
- PENDING, at an edge with write_en=0:
  - if cnt!=0: cnt decrements.
  - if cnt==0: cfg_active<=shadow; cfg_valid<=1; apply_pulse<=1; state<=IDLE.
- Commit latency: a single write sampled at edge E0 updates cfg_active at edge E0+SETTLE. apply_pulse is high for the cycle following that edge.
- Write at the cnt==0 edge: the write wins. Shadow reloads, the counter restarts, and no commit occurs at that edge.
- write_en held high continuously: no commit occurs. Commit happens SETTLE edges after the last high sample.
- EMPTY and IDLE differ only in cfg_valid. Both go to PENDING on a write.
- apply_pulse is 0 in every cycle other than the one following a commit edge.
- Read port:
  - At each edge with rd_req=1: rd_ack<=1; rd_data<=cfg_active as it stood before that edge; rd_err<=~cfg_valid (pre-edge value).
  - At each edge with rd_req=0: rd_ack<=0 and rd_data holds its value.
  - rd_req held high gives rd_ack on every cycle.
- Read and commit at the same edge: the read returns the pre-commit value, and rd_err reflects cfg_valid before the commit.
- write_count never wraps.

Decomposition:
- Shared package cfg_pkg holds:
  - the CFG_WIDTH=35 constant, shared with ControlUnit;
  - the state typedef and its encodings (EMPTY/IDLE/PENDING);
  - the dbg_state width constant.
- One sub-module, sat_counter (parameter CNT_W; ports clk, arst, inc, count), implements the saturating write counter.
- The settle counter and FSM stay inline.

Test Plan:
- Reset then idle 10 cycles -> dbg_state=0, cfg_valid=0, all outputs 0. rd_req pulse -> rd_ack=1 with rd_err=1 and rd_data=0 one cycle later.
- Single write of config_in=35'h0_1234_5678 at E0 with SETTLE=4 -> dbg_state=2 from E0, cfg_active=35'h012345678 at E4, apply_pulse high for exactly one cycle, write_count=1, dbg_state=1.
- Writes of 35'h1, 35'h2, 35'h3 three cycles apart (gaps under SETTLE) -> no intermediate commit; cfg_active=35'h3 exactly 4 edges after the third write; write_count=3; one apply_pulse only.
- rd_req asserted at the commit edge of a second write (active 35'hA to 35'hB) -> rd_data=35'hA, rd_err=0. rd_req at the next edge -> rd_data=35'hB.
- arst asserted mid-PENDING (two edges after a write) -> immediate clear, with no clock edge needed: cfg_active=0, cfg_valid=0, dbg_state=0. No apply_pulse follows after arst is released.
- 260 consecutive write_en cycles with CNT_W=8 -> write_count stops at 255. Commit happens 4 edges after write_en falls, with cfg_active equal to the last config_in.
